// File: rtl/shreg_serdes_ctrl.sv
// Serial TX/RX sequencer for an external shift register: LOAD, then NBIT shifts of D+1 clocks each, then FINISH.
// Latency is 3+NBIT*(D+1) cycles from accept to done; start is accepted only when ready=1 and ignored while busy.
module shreg_serdes_ctrl #(
  parameter int NBIT  = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  input  logic             mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] bit_div,
  input  logic [NBIT-1:0]  tx_data,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             bit_strobe,
  input  logic [NBIT-1:0]  reg_q,
  output logic [NBIT-1:0]  reg_d,
  output logic             reg_load,
  output logic             reg_shl,
  output logic             reg_shr,
  output logic             reg_shin,
  output logic [NBIT-1:0]  rx_data,
  output logic             done
);

  localparam int BCW = $clog2(NBIT + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(NBIT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

  typedef struct packed {
    logic             mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic [NBIT-1:0]  data;
  } cfg_t;

  state_t           state;
  state_t           state_nxt;
  cfg_t             cfg;
  logic [DIV_W-1:0] div_cnt;
  logic [BCW-1:0]   bit_cnt;

  always_ff @(posedge clk_main) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    busy       = 1'b1;
    reg_load   = 1'b0;
    reg_d      = '0;
    bit_strobe = 1'b0;
    reg_shl    = 1'b0;
    reg_shr    = 1'b0;
    reg_shin   = 1'b0;
    serial_out = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        reg_load = 1'b1;
        if (!cfg.mode) reg_d = cfg.data;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_strobe = (div_cnt == cfg.div);
        reg_shl    = bit_strobe & ~cfg.dir;
        reg_shr    = bit_strobe & cfg.dir;
        reg_shin   = cfg.mode & serial_in;
        // TX bit comes straight off the register edge being shifted out
        if (!cfg.mode) serial_out = cfg.dir ? reg_q[0] : reg_q[NBIT-1];
        if (bit_strobe && (bit_cnt == LAST_BIT)) state_nxt = FINISH;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      cfg     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if ((state == IDLE) && start) cfg <= {mode, dir, bit_div, tx_data};
      case (state)
        LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (bit_strobe) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + BCW'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        FINISH: if (cfg.mode) rx_data <= reg_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_serdes_ctrl.sv
// Directed bench for shreg_serdes_ctrl with a behavioural 8-bit shift register attached.
module tb_shreg_serdes_ctrl;

  logic       clk_main;
  logic       reset;
  logic       start;
  logic       ready;
  logic       busy;
  logic       mode;
  logic       dir;
  logic [7:0] bit_div;
  logic [7:0] tx_data;
  logic       serial_in;
  logic       serial_out;
  logic       bit_strobe;
  logic [7:0] reg_q;
  logic [7:0] reg_d;
  logic       reg_load;
  logic       reg_shl;
  logic       reg_shr;
  logic       reg_shin;
  logic [7:0] rx_data;
  logic       done;

  int vectors;
  int miscompares;

  shreg_serdes_ctrl #(.NBIT(8), .DIV_W(8)) dut (
    .clk_main(clk_main), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .mode(mode), .dir(dir), .bit_div(bit_div), .tx_data(tx_data),
    .serial_in(serial_in), .serial_out(serial_out), .bit_strobe(bit_strobe),
    .reg_q(reg_q), .reg_d(reg_d), .reg_load(reg_load), .reg_shl(reg_shl),
    .reg_shr(reg_shr), .reg_shin(reg_shin), .rx_data(rx_data), .done(done)
  );

  // attached nbit shift register, sharing the controller's reset
  always @(posedge clk_main) begin
    if (reset)        reg_q <= 8'h00;
    else if (reg_load) reg_q <= reg_d;
    else if (reg_shl)  reg_q <= {reg_q[6:0], reg_shin};
    else if (reg_shr)  reg_q <= {reg_shin, reg_q[7:1]};
  end

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  task automatic tick;
    @(posedge clk_main);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MSB-first TX with D=0 from the current (IDLE) cycle T0 through done at T11
  task automatic tx_d0(input logic [7:0] w);
    start = 1'b1; mode = 1'b0; dir = 1'b0; bit_div = 8'd0; tx_data = w;
    chk("tx_ready_t0", ready, 1);
    tick;
    start = 1'b0;
    chk("tx_load", reg_load, 1);
    chk("tx_reg_d", reg_d, w);
    chk("tx_ready_t1", ready, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("tx_bit", serial_out, w[7-i]);
      chk("tx_strobe", bit_strobe, 1);
      chk("tx_shl", reg_shl, 1);
      chk("tx_shr", reg_shr, 0);
    end
    tick;
    chk("tx_finish_ready", ready, 0);
    chk("tx_finish_done", done, 0);
    chk("tx_finish_sout", serial_out, 1);
    tick;
    chk("tx_done", done, 1);
    chk("tx_done_ready", ready, 1);
  endtask

  logic [7:0] w;
  logic [7:0] got;
  int         ndone;
  int         d1;
  int         d2;
  int         ld2;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; start = 1'b0; mode = 1'b0; dir = 1'b0; bit_div = 8'd0;
    tx_data = 8'h00; serial_in = 1'b0;
    tick; tick;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sout", serial_out, 1);
    chk("rst_ctrl", {bit_strobe, done, reg_load, reg_shl, reg_shr, reg_shin}, 0);
    chk("rst_reg_d", reg_d, 0);
    chk("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    tick;

    // TX MSB-first, D=0, A5
    tx_d0(8'hA5);
    tick;
    chk("t1_done_clear", done, 0);

    // TX LSB-first, D=2, 81; inputs changed after accept must not matter
    w = 8'h81;
    start = 1'b1; mode = 1'b0; dir = 1'b1; bit_div = 8'd2; tx_data = w;
    tick;
    start = 1'b0; dir = 1'b0; bit_div = 8'd0; tx_data = 8'h00;
    chk("t2_load", reg_load, 1);
    for (int i = 0; i < 24; i++) begin
      tick;
      chk("t2_bit", serial_out, w[i/3]);
      chk("t2_shr", reg_shr, (i % 3 == 2) ? 1 : 0);
      chk("t2_shl", reg_shl, 0);
    end
    tick;
    chk("t2_finish_done", done, 0);
    tick;
    chk("t2_done_t27", done, 1);
    chk("t2_rx_unchanged", rx_data, 0);
    tick;

    // RX MSB-first, D=1, serial 3C
    w = 8'h3C;
    start = 1'b1; mode = 1'b1; dir = 1'b0; bit_div = 8'd1; tx_data = 8'hFF;
    tick;
    start = 1'b0;
    chk("t3_load", reg_load, 1);
    chk("t3_reg_d", reg_d, 0);
    for (int i = 0; i < 16; i++) begin
      tick;
      serial_in = w[7-(i/2)];
      #1;
      chk("t3_strobe", bit_strobe, (i % 2 == 1) ? 1 : 0);
      chk("t3_sout", serial_out, 1);
      if (i % 2 == 1) chk("t3_shin", reg_shin, w[7-(i/2)]);
    end
    tick;
    serial_in = 1'b0;
    chk("t3_finish_rx_old", rx_data, 0);
    chk("t3_finish_done", done, 0);
    tick;
    chk("t3_done", done, 1);
    chk("t3_rx_data", rx_data, 8'h3C);
    tick;

    // start during SHIFT is ignored
    start = 1'b1; mode = 1'b0; dir = 1'b0; bit_div = 8'd0; tx_data = 8'h5A;
    got = 8'h00; ndone = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 1) start = 1'b0;
      if (c == 4 || c == 5) begin start = 1'b1; tx_data = 8'hFF; mode = 1'b1; end
      if (c == 6) start = 1'b0;
      if (c == 4) chk("t4_busy_ready", ready, 0);
      if (c >= 2 && c <= 9) got = {got[6:0], serial_out};
      if (done) ndone++;
    end
    chk("t4_word", got, 8'h5A);
    chk("t4_one_done", ndone, 1);
    chk("t4_idle", ready, 1);
    chk("t4_rx_kept", rx_data, 8'h3C);

    // reset at the 4th bit of a TX
    w = 8'hC3;
    start = 1'b1; mode = 1'b0; dir = 1'b0; bit_div = 8'd0; tx_data = w;
    tick;
    start = 1'b0;
    for (int c = 2; c <= 5; c++) tick;
    chk("t5_bit4", serial_out, w[4]);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t5_ready", ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_sout", serial_out, 1);
    chk("t5_ctrl", {bit_strobe, done, reg_load, reg_shl, reg_shr, reg_shin}, 0);
    chk("t5_reg_d", reg_d, 0);
    chk("t5_rx_cleared", rx_data, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (done) ndone++;
    end
    chk("t5_no_done", ndone, 0);
    tx_d0(8'h96);
    tick;

    // start held through done: back-to-back transfers
    start = 1'b1; mode = 1'b0; dir = 1'b0; bit_div = 8'd0; tx_data = 8'h0F;
    ndone = 0; d1 = -1; d2 = -1; ld2 = -1;
    for (int c = 1; c <= 26; c++) begin
      tick;
      if (c == 12) start = 1'b0;
      if (done) begin
        ndone++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (reg_load && c > 1) ld2 = c;
    end
    chk("t6_done_count", ndone, 2);
    chk("t6_done1", d1, 11);
    chk("t6_done2", d2, 22);
    chk("t6_load2", ld2, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
